// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, waits for lock, qualifies it for
// STABLE_CYCLES consecutive cycles, then releases the downstream reset.
// Re-enters the PLL reset sequence on a lock timeout or on loss of lock in RUN.
// Optional feature macro: PLL_SUP_LOST_CNT_EN builds the lost-lock counter;
// without it lost_cnt is tied to zero.
module pll_lock_supervisor #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 65535,
  parameter int unsigned STABLE_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       locked,
  output logic [3:0] retry_cnt,
  output logic [7:0] lost_cnt
);

  localparam logic [1:0] StResetPll = 2'd0;
  localparam logic [1:0] StWaitLock = 2'd1;
  localparam logic [1:0] StStable   = 2'd2;
  localparam logic [1:0] StRun      = 2'd3;

  // Terminal counts; the counter starts at 0 on state entry so each compares
  // against N-1, which always fits in 16 bits and never lets the counter wrap.
  localparam logic [15:0] RstLast     = 16'(RST_CYCLES - 1);
  localparam logic [15:0] TimeoutLast = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] StableLast  = 16'(STABLE_CYCLES - 1);

  logic [1:0]  sync_q;
  logic        lock_s;
  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  retry_q;
  logic        retry_inc;
  logic        pll_rst_q, sys_rst_q, locked_q;

  assign lock_s = sync_q[1];

  // Two-flop synchronizer for the asynchronous PLL lock indication.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pll_lock};
    end
  end

  // Next-state and counter logic; every transition clears the counter.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 16'd1;
    retry_inc = 1'b0;
    case (state_q)
      StResetPll: begin
        if (cnt_q == RstLast) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end
      end
      StWaitLock: begin
        if (lock_s) begin
          state_d = StStable;
          cnt_d   = '0;
        end else if (cnt_q == TimeoutLast) begin
          state_d   = StResetPll;
          cnt_d     = '0;
          retry_inc = 1'b1;
        end
      end
      StStable: begin
        if (!lock_s) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == StableLast) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      StRun: begin
        // Nothing is timed in RUN, so the counter holds to avoid wrapping.
        cnt_d = cnt_q;
        if (!lock_s) begin
          state_d = StResetPll;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StResetPll;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and outputs; outputs are decoded from the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StResetPll;
      cnt_q     <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pll_rst_q <= (state_d == StResetPll);
      sys_rst_q <= (state_d != StRun);
      locked_q  <= (state_d == StRun);
      if (retry_inc && (retry_q != 4'hF)) begin
        retry_q <= retry_q + 4'd1;
      end
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst   = sys_rst_q;
  assign locked    = locked_q;
  assign retry_cnt = retry_q;

`ifdef PLL_SUP_LOST_CNT_EN
  logic [7:0] lost_q;
  logic       lost_inc;

  assign lost_inc = (state_q == StRun) && !lock_s;

  // Saturating count of lock losses while running.
  always_ff @(posedge clk) begin
    if (rst) begin
      lost_q <= '0;
    end else if (lost_inc && (lost_q != 8'hFF)) begin
      lost_q <= lost_q + 8'd1;
    end
  end

  assign lost_cnt = lost_q;
`else
  assign lost_cnt = 8'd0;
`endif

endmodule
